// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one single-port memory between fetch and data requesters
// One access outstanding at a time; a wait counter bounds each access and sets a sticky err on expiry.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ack,
  input  logic [31:0] m_rdata,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

  state_t      state;
  logic [4:0]  wait_cnt;
  logic        last_grant;
  logic        grant_d;

  assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

  // last_grant: 0 = instruction, 1 = data; on a tie the side not served last wins
  assign grant_d = d_req & (~i_req | ~last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= 5'd0;
      last_grant <= 1'b0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= 32'd0;
      m_wdata    <= 32'd0;
      i_ready    <= 1'b0;
      i_rdata    <= 32'd0;
      d_ready    <= 1'b0;
      d_rdata    <= 32'd0;
      err        <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= BUSY_D;
            last_grant <= 1'b1;
            m_req      <= 1'b1;
            m_we       <= d_we;
            m_addr     <= d_addr;
            m_wdata    <= d_wdata;
            wait_cnt   <= 5'd0;
          end else if (i_req) begin
            state      <= BUSY_I;
            last_grant <= 1'b0;
            m_req      <= 1'b1;
            m_we       <= 1'b0;
            m_addr     <= i_addr;
            m_wdata    <= 32'd0;
            wait_cnt   <= 5'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          // an expired wait completes the access with zero data instead of hanging the pipeline
          if (m_ack || (wait_cnt == WAIT_LAST)) begin
            state <= RESP;
            m_req <= 1'b0;
            if (!m_ack) err <= 1'b1;
            if (state == BUSY_I) begin
              i_ready <= 1'b1;
              i_rdata <= m_ack ? m_rdata : 32'd0;
            end else begin
              d_ready <= 1'b1;
              if (!m_we) d_rdata <= m_ack ? m_rdata : 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - bench for mem_arbiter: directed scenarios plus a randomized run against a transaction model
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk, rst;
  logic        i_req, i_ready;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ready;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        stall, err;

  int n_tests = 0;
  int n_fail  = 0;

  int ack_lat   = 1;
  bit rand_lat  = 0;
  bit ack_noise = 0;
  bit ack_fixed = 0;
  logic [31:0] ack_data = 32'd0;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall(stall), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // memory responder: acks on the lat-th cycle of m_req, optional random acks while idle
  initial begin
    int req_cnt, cur_lat, lat;
    req_cnt = 0;
    cur_lat = 1;
    m_ack = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || !m_req) begin
        req_cnt = 0;
        m_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        m_rdata = $urandom;
      end else begin
        req_cnt++;
        if (req_cnt == 1 && rand_lat) cur_lat = $urandom_range(1, 4);
        lat = rand_lat ? cur_lat : ack_lat;
        if (lat != 0 && req_cnt == lat) begin
          m_ack = 1'b1;
          m_rdata = ack_fixed ? ack_data : mem_word(m_addr);
        end else begin
          m_ack = 1'b0;
          m_rdata = $urandom;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    ack_lat = 1; rand_lat = 0; ack_noise = 0; ack_fixed = 0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b0;
    cyc();
    cyc();
    mid();
    n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %0h exp 0", m_req); end
    n_tests++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we: got %0h exp 0", m_we); end
    n_tests++; if (m_addr !== 32'd0) begin n_fail++; $display("FAIL reset_m_addr: got %0h exp 0", m_addr); end
    n_tests++; if (m_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_m_wdata: got %0h exp 0", m_wdata); end
    n_tests++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready: got %0h exp 0", i_ready); end
    n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %0h exp 0", d_ready); end
    n_tests++; if (i_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_i_rdata: got %0h exp 0", i_rdata); end
    n_tests++; if (d_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_d_rdata: got %0h exp 0", d_rdata); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h exp 0", err); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %0h exp 1", stall); end
    i_req = 1'b0;
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    ack_lat = 1; ack_fixed = 1; ack_data = 32'h2002_000A;
    i_req = 1'b1; i_addr = 32'h40;
    mid();
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c0: got %0h exp 1", stall); end
    n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_m_req_c0: got %0h exp 0", m_req); end
    cyc();
    mid();
    n_tests++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL fetch_m_req_c1: got %0h exp 1", m_req); end
    n_tests++; if (m_addr !== 32'h40) begin n_fail++; $display("FAIL fetch_m_addr: got %0h exp 40", m_addr); end
    n_tests++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL fetch_m_we: got %0h exp 0", m_we); end
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_c1: got %0h exp 1", stall); end
    cyc();
    mid();
    n_tests++; if (i_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_i_ready_c2: got %0h exp 1", i_ready); end
    n_tests++; if (i_rdata !== 32'h2002_000A) begin n_fail++; $display("FAIL fetch_i_rdata: got %0h exp 2002000a", i_rdata); end
    n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_m_req_c2: got %0h exp 0", m_req); end
    i_req = 1'b0;
    cyc();
    mid();
    n_tests++; if (i_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_i_ready_c3: got %0h exp 0", i_ready); end
    ack_fixed = 0;
    cyc();
  endtask

  task automatic test_tie();
    int ci, cd;
    bit first_seen;
    ci = -1; cd = -1; first_seen = 0;
    do_reset();
    ack_lat = 1;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    for (int k = 0; k < 14; k++) begin
      mid();
      if (m_req && !first_seen) begin
        first_seen = 1;
        n_tests++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL tie_first_grant: got addr %0h exp 100", m_addr); end
      end
      if (d_ready && cd < 0) begin
        cd = k; d_req = 1'b0;
        n_tests++; if (d_rdata !== mem_word(32'h100)) begin n_fail++; $display("FAIL tie_d_rdata: got %0h exp %0h", d_rdata, mem_word(32'h100)); end
      end
      if (i_ready && ci < 0) begin
        ci = k; i_req = 1'b0;
        n_tests++; if (i_rdata !== mem_word(32'h200)) begin n_fail++; $display("FAIL tie_i_rdata: got %0h exp %0h", i_rdata, mem_word(32'h200)); end
      end
      cyc();
    end
    n_tests++; if (cd != 2) begin n_fail++; $display("FAIL tie_d_ready_cycle: got %0d exp 2", cd); end
    n_tests++; if (ci - cd != 3 || ci < 0) begin n_fail++; $display("FAIL tie_i_after_d: got %0d exp 3", ci - cd); end
  endtask

  task automatic test_store();
    ack_lat = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'h55AA;
    mid();
    n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL store_stall_c0: got %0h exp 1", stall); end
    for (int k = 1; k <= 3; k++) begin
      cyc();
      if (k == 2) begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'b0; end
      mid();
      n_tests++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL store_m_req_c%0d: got %0h exp 1", k, m_req); end
      n_tests++; if (m_we !== 1'b1) begin n_fail++; $display("FAIL store_m_we_c%0d: got %0h exp 1", k, m_we); end
      n_tests++; if (m_wdata !== 32'h55AA) begin n_fail++; $display("FAIL store_m_wdata_c%0d: got %0h exp 55aa", k, m_wdata); end
      n_tests++; if (m_addr !== 32'h8) begin n_fail++; $display("FAIL store_m_addr_c%0d: got %0h exp 8", k, m_addr); end
      n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL store_d_ready_c%0d: got %0h exp 0", k, d_ready); end
    end
    cyc();
    mid();
    n_tests++; if (d_ready !== 1'b1) begin n_fail++; $display("FAIL store_d_ready: got %0h exp 1", d_ready); end
    n_tests++; if (d_rdata !== mem_word(32'h100)) begin n_fail++; $display("FAIL store_d_rdata_kept: got %0h exp %0h", d_rdata, mem_word(32'h100)); end
    n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL store_m_req_drop: got %0h exp 0", m_req); end
    d_req = 1'b0; d_we = 1'b0;
    cyc();
    mid();
    n_tests++; if (d_ready !== 1'b0) begin n_fail++; $display("FAIL store_d_ready_pulse: got %0h exp 0", d_ready); end
    cyc();
  endtask

  task automatic test_timeout();
    int hi;
    bit done;
    hi = 0; done = 0;
    ack_lat = 0;
    i_req = 1'b1; i_addr = 32'h80;
    for (int k = 0; k < 40 && !done; k++) begin
      mid();
      if (k == 0) begin
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_before: got %0h exp 0", err); end
      end
      if (m_req) hi++;
      if (i_ready) begin
        done = 1; i_req = 1'b0;
        n_tests++; if (i_rdata !== 32'd0) begin n_fail++; $display("FAIL timeout_i_rdata: got %0h exp 0", i_rdata); end
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_set: got %0h exp 1", err); end
      end
      cyc();
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL timeout_ready_seen: got none exp pulse"); end
    n_tests++; if (hi != TIMEOUT) begin n_fail++; $display("FAIL timeout_m_req_cycles: got %0d exp %0d", hi, TIMEOUT); end
    ack_lat = 1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    cyc();
    cyc();
    d_req = 1'b0;
    repeat (3) cyc();
    mid();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err_sticky: got %0h exp 1", err); end
    do_reset();
    mid();
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_err_cleared: got %0h exp 0", err); end
  endtask

  task automatic test_reset_mid();
    bit bad_ready, bad_req;
    bad_ready = 0; bad_req = 0;
    do_reset();
    ack_lat = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    cyc();
    cyc();
    mid();
    n_tests++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL rmid_busy: got %0h exp 1", m_req); end
    rst = 1'b0;
    d_req = 1'b0;
    #1;
    n_tests++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL rmid_m_req: got %0h exp 0", m_req); end
    n_tests++; if (m_addr !== 32'd0) begin n_fail++; $display("FAIL rmid_m_addr: got %0h exp 0", m_addr); end
    n_tests++; if (m_we !== 1'b0 || m_wdata !== 32'd0) begin n_fail++; $display("FAIL rmid_m_we_wdata: got %0h/%0h exp 0/0", m_we, m_wdata); end
    n_tests++; if (d_ready !== 1'b0 || i_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_ready: got %0h/%0h exp 0/0", d_ready, i_ready); end
    n_tests++; if (err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL rmid_err_stall: got %0h/%0h exp 0/0", err, stall); end
    cyc();
    rst = 1'b1;
    ack_lat = 1;
    for (int k = 0; k < 8; k++) begin
      mid();
      if (d_ready) bad_ready = 1;
      if (m_req) bad_req = 1;
      cyc();
    end
    n_tests++; if (bad_ready) begin n_fail++; $display("FAIL rmid_no_ready: got d_ready pulse exp none"); end
    n_tests++; if (bad_req) begin n_fail++; $display("FAIL rmid_no_access: got m_req exp none"); end
  endtask

  task automatic test_back_to_back();
    int gcyc[8];
    int gd[8];
    int ng;
    bit prev;
    ng = 0; prev = 0;
    for (int j = 0; j < 8; j++) begin gcyc[j] = -1; gd[j] = -1; end
    do_reset();
    ack_lat = 1;
    i_req = 1'b1; i_addr = 32'h1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    for (int k = 0; k < 12; k++) begin
      mid();
      if (m_req && !prev && ng < 8) begin
        gcyc[ng] = k;
        gd[ng] = (m_addr == 32'h2000) ? 1 : 0;
        ng++;
      end
      prev = m_req;
      cyc();
    end
    i_req = 1'b0; d_req = 1'b0;
    n_tests++; if (ng != 4) begin n_fail++; $display("FAIL b2b_grant_count: got %0d exp 4", ng); end
    for (int j = 0; j < 4; j++) begin
      n_tests++; if (gd[j] != ((j % 2 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL b2b_side_%0d: got data=%0d exp data=%0d", j, gd[j], (j % 2 == 0) ? 1 : 0); end
      n_tests++; if (gcyc[j] != 1 + 3 * j) begin n_fail++; $display("FAIL b2b_cycle_%0d: got %0d exp %0d", j, gcyc[j], 1 + 3 * j); end
    end
    repeat (4) cyc();
  endtask

  // transaction model: a grant decided in a free cycle occupies the memory until its ack,
  // the ready pulses the cycle after the ack, and the next decision follows one cycle later
  task automatic test_random();
    int start_at, resp_at, free_at;
    bit busy, last_d, cur_d, cur_we, exp_ir, exp_dr, exp_stall;
    logic [31:0] cur_addr, cur_wdata, exp_ird, exp_drd;
    do_reset();
    rand_lat = 1; ack_noise = 1;
    start_at = -1; resp_at = -1; free_at = 0;
    busy = 0; last_d = 0; cur_d = 0; cur_we = 0;
    cur_addr = 0; cur_wdata = 0; exp_ird = 0; exp_drd = 0;
    for (int c = 0; c < 500; c++) begin
      cyc();
      if (i_req && i_ready) i_req = 1'b0;
      if (!i_req && $urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom & ~32'h3; end
      if (d_req && d_ready) d_req = 1'b0;
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom & ~32'h3; d_wdata = $urandom;
      end
      mid();
      if (c == start_at) busy = 1;
      exp_ir = (c == resp_at) && !cur_d;
      exp_dr = (c == resp_at) && cur_d;
      if (exp_ir) exp_ird = mem_word(cur_addr);
      if (exp_dr && !cur_we) exp_drd = mem_word(cur_addr);
      exp_stall = (i_req && !exp_ir) || (d_req && !exp_dr);
      n_tests++; if (i_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_i_ready c%0d: got %0h exp %0h", c, i_ready, exp_ir); end
      n_tests++; if (d_ready !== exp_dr) begin n_fail++; $display("FAIL rnd_d_ready c%0d: got %0h exp %0h", c, d_ready, exp_dr); end
      n_tests++; if (i_rdata !== exp_ird) begin n_fail++; $display("FAIL rnd_i_rdata c%0d: got %0h exp %0h", c, i_rdata, exp_ird); end
      n_tests++; if (d_rdata !== exp_drd) begin n_fail++; $display("FAIL rnd_d_rdata c%0d: got %0h exp %0h", c, d_rdata, exp_drd); end
      n_tests++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0h exp %0h", c, stall, exp_stall); end
      n_tests++; if (m_req !== busy) begin n_fail++; $display("FAIL rnd_m_req c%0d: got %0h exp %0h", c, m_req, busy); end
      if (busy) begin
        n_tests++; if (m_addr !== cur_addr || m_we !== cur_we) begin n_fail++; $display("FAIL rnd_m_addr_we c%0d: got %0h/%0h exp %0h/%0h", c, m_addr, m_we, cur_addr, cur_we); end
        if (cur_we) begin
          n_tests++; if (m_wdata !== cur_wdata) begin n_fail++; $display("FAIL rnd_m_wdata c%0d: got %0h exp %0h", c, m_wdata, cur_wdata); end
        end
        if (m_ack) begin busy = 0; resp_at = c + 1; free_at = c + 2; end
      end else if (c == free_at) begin
        if (i_req || d_req) begin
          cur_d = d_req && (!i_req || !last_d);
          last_d = cur_d;
          cur_addr = cur_d ? d_addr : i_addr;
          cur_we = cur_d && d_we;
          cur_wdata = d_wdata;
          start_at = c + 1;
        end else begin
          free_at = c + 1;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    rand_lat = 0; ack_noise = 0;
    repeat (8) cyc();
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    test_reset();
    test_fetch();
    test_tie();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, the maximum number of BUSY cycles to wait for m_ack.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports i_req/i_addr[31:0], inputs, the fetch request and address; held by requester until i_ready.
REQ-005 The block SHALL have ports i_ready (1) and i_rdata (32), outputs, the fetch completion pulse and registered instruction word.
REQ-006 The block SHALL have ports d_req (1), d_we (1), d_addr (32), d_wdata (32), inputs, the data-stage request; held until d_ready.
REQ-007 The block SHALL have ports d_ready (1) and d_rdata (32), outputs, the data completion pulse and registered load data.
REQ-008 The block SHALL have ports m_req (1), m_we (1), m_addr (32), m_wdata (32), outputs, the shared single-port memory request.
REQ-009 The block SHALL have ports m_ack (1) and m_rdata (32), inputs, the memory completion flag and read data, valid together.
REQ-010 The block SHALL have port stall, output, 1, the pipeline freeze signal.
REQ-011 The block SHALL have port err, output, 1, a sticky timeout flag.

Function
REQ-012 FSM states SHALL be IDLE, BUSY_I, BUSY_D, RESP; only one memory access SHALL be outstanding.
REQ-013 In IDLE with exactly one request pending, that side SHALL be granted at the next edge.
REQ-014 In IDLE with both pending, the side not granted last SHALL win (round-robin on a last_grant bit, reset value = instruction, so data wins the first tie).
REQ-015 On grant, m_addr, m_we (0 for fetch) and m_wdata SHALL be latched from the winner, and m_req SHALL be 1 throughout BUSY_*.
REQ-016 Latched m_* SHALL stay stable in BUSY_* regardless of requester input changes.
REQ-017 In BUSY_* with m_ack=1 at an edge: m_rdata SHALL be captured into i_rdata (BUSY_I) or d_rdata (BUSY_D, read only), m_req SHALL drop, and state SHALL become RESP.
REQ-018 In RESP the matching ready SHALL be 1 for exactly one cycle; next state SHALL be IDLE; no grant SHALL be made from RESP.
REQ-019 For a data write, d_rdata SHALL keep its previous value.
REQ-020 Minimum latency: request seen in IDLE at cycle 0, m_req high cycle 1, ready high cycle 2 when m_ack=1 in cycle 1; each access SHALL occupy at least 3 cycles.
REQ-021 A 5-bit wait counter SHALL clear on grant and increment each BUSY cycle without m_ack.
REQ-022 If the counter reaches TIMEOUT-1 without m_ack, the FSM SHALL go to RESP, pulse the matching ready with rdata = 0, and set err.
REQ-023 err SHALL remain 1 until reset.
REQ-024 stall SHALL be combinational: (i_req & ~i_ready) | (d_req & ~d_ready).
REQ-025 m_ack outside BUSY_* SHALL be ignored.
REQ-026 A request dropped before its grant SHALL not be granted; a request dropped after its grant SHALL still complete, with its ready pulse ignored.

Reset
REQ-027 When rst=0, immediately: state=IDLE; m_req, m_we, i_ready, d_ready, err=0; m_addr, m_wdata, i_rdata, d_rdata=0; counter=0; last_grant=instruction.
REQ-028 Reset during BUSY_* SHALL abort the access with m_req low in the same cycle and no ready pulse after release.

Verification
REQ-029 Fetch only: i_req=1, i_addr=0x40, memory acks 1 cycle later with 0x2002000A -> m_addr=0x40, m_we=0; i_ready pulse in cycle 2 with i_rdata=0x2002000A; stall=1 in cycles 0-1.
REQ-030 Tie: i_req and d_req (read 0x100) together from reset -> data granted first; i_ready follows d_ready by exactly 3 cycles with a 1-cycle ack memory.
REQ-031 Store: d_we=1, d_addr=0x8, d_wdata=0x55AA, ack after 3 cycles -> m_we=1, m_wdata=0x55AA stable 3 cycles; d_ready 1 cycle; d_rdata unchanged.
REQ-032 Timeout: fetch with m_ack held 0 -> m_req high exactly 16 cycles; i_ready pulse with i_rdata=0; err=1 until reset.
REQ-033 Reset mid-access: rst=0 in BUSY_D cycle 2 -> m_req=0 in the same cycle, all outputs at reset values, no d_ready after release.
REQ-034 Back-to-back: continuous i_req and d_req for 12 cycles -> grants alternate D,I,D,I, one per 3 cycles with 1-cycle ack.
